// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requesters and register-file write port bundle
// The arbiter uses the slave view; a requester/register-file side uses master.
interface regfile_wb_arbiter_if #(
   parameter int REG_WIDTH = 32,
   parameter int RD_W      = 5
);
   logic                 req0_valid;
   logic                 req0_ready;
   logic [RD_W-1:0]      req0_rd;
   logic [REG_WIDTH-1:0] req0_data;
   logic                 req1_valid;
   logic                 req1_ready;
   logic [RD_W-1:0]      req1_rd;
   logic [REG_WIDTH-1:0] req1_data;
   logic [RD_W-1:0]      rf_rd;
   logic [REG_WIDTH-1:0] rf_rd_din;
   logic                 rf_reg_write;
   logic                 init_busy;

   modport master (
      output req0_valid, req0_rd, req0_data,
      output req1_valid, req1_rd, req1_data,
      input  req0_ready, req1_ready,
      input  rf_rd, rf_rd_din, rf_reg_write, init_busy
   );

   modport slave (
      input  req0_valid, req0_rd, req0_data,
      input  req1_valid, req1_rd, req1_data,
      output req0_ready, req1_ready,
      output rf_rd, rf_rd_din, rf_reg_write, init_busy
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-channel writeback arbiter and zero-init sweep for the regfile
// Optional ch1 starvation guard: REGFILE_WB_ARB_STARVE_GUARD_EN.
module regfile_wb_arbiter #(
   parameter int REG_WIDTH = 32,
   parameter int NUM_REGS  = 32,
   parameter int MAX_WAIT  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_wb_arbiter_if.slave  bus
);
   localparam int RD_W = $clog2(NUM_REGS);
   localparam logic [RD_W-1:0] LAST_IDX = RD_W'(NUM_REGS - 1);

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [RD_W-1:0]      idx;
   logic [RD_W-1:0]      idx_next;
   logic [RD_W-1:0]      rd_q;
   logic [RD_W-1:0]      rd_next;
   logic [REG_WIDTH-1:0] din_q;
   logic [REG_WIDTH-1:0] din_next;
   logic                 we_q;
   logic                 we_next;
   logic                 busy_q;
   logic                 busy_next;
   logic                 ready0;
   logic                 ready1;
   logic                 force1;
   logic                 run_en;

   if (MAX_WAIT < 1) begin : g_max_wait_out_of_range
   end

   // Grants open only once init_busy has dropped, one cycle after the last sweep write.
   assign run_en = (state == RUN) & ~busy_q;

`ifdef REGFILE_WB_ARB_STARVE_GUARD_EN
   localparam int WC_W = $clog2(MAX_WAIT + 1);
   localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_WAIT);

   logic [WC_W-1:0] wait_cnt;
   logic [WC_W-1:0] wait_next;

   assign force1 = (wait_cnt == WAIT_MAX) & bus.req1_valid;

   always_comb begin
      wait_next = wait_cnt;
      if (run_en) begin
         if (bus.req1_valid && !ready1) begin
            if (wait_cnt != WAIT_MAX) begin
               wait_next = wait_cnt + WC_W'(1);
            end
         end else begin
            wait_next = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_next;
      end
   end
`else
   assign force1 = 1'b0;
`endif

   always_comb begin
      state_next = state;
      idx_next   = idx;
      rd_next    = rd_q;
      din_next   = din_q;
      we_next    = 1'b0;
      busy_next  = (state == INIT);
      ready0     = 1'b0;
      ready1     = 1'b0;
      case (state)
         INIT: begin
            rd_next  = idx;
            din_next = '0;
            we_next  = 1'b1;
            idx_next = idx + RD_W'(1);
            if (idx == LAST_IDX) begin
               state_next = RUN;
               idx_next   = '0;
            end
         end
         RUN: begin
            if (run_en) begin
               ready0 = bus.req0_valid & ~force1;
               ready1 = bus.req1_valid & (~bus.req0_valid | force1);
            end
            // Writes to x0 are accepted and consumed but never reach the regfile.
            if (ready0) begin
               rd_next  = bus.req0_rd;
               din_next = bus.req0_data;
               we_next  = (bus.req0_rd != '0);
            end else if (ready1) begin
               rd_next  = bus.req1_rd;
               din_next = bus.req1_data;
               we_next  = (bus.req1_rd != '0);
            end
         end
         default: begin
            state_next = INIT;
            idx_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= INIT;
         idx    <= '0;
         rd_q   <= '0;
         din_q  <= '0;
         we_q   <= 1'b0;
         busy_q <= 1'b1;
      end else begin
         state  <= state_next;
         idx    <= idx_next;
         rd_q   <= rd_next;
         din_q  <= din_next;
         we_q   <= we_next;
         busy_q <= busy_next;
      end
   end

   assign bus.req0_ready   = ready0;
   assign bus.req1_ready   = ready1;
   assign bus.rf_rd        = rd_q;
   assign bus.rf_rd_din    = din_q;
   assign bus.rf_reg_write = we_q;
   assign bus.init_busy    = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
// Stimulus pushes the reference model's expected per-cycle outputs; a negedge monitor pops them.
module tb_regfile_wb_arbiter;
   localparam int REG_WIDTH = 32;
   localparam int NUM_REGS  = 32;
   localparam int MAX_WAIT  = 4;
`ifdef REGFILE_WB_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] din;
      logic        busy;
      logic        rdy0;
      logic        rdy1;
      logic        chk_rd;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.REG_WIDTH(REG_WIDTH), .RD_W(5)) bus ();

   regfile_wb_arbiter #(
      .REG_WIDTH(REG_WIDTH),
      .NUM_REGS (NUM_REGS),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;

   // Reference model: t counts edges since the last sampled reset.
   int          t = 0;
   int          wcnt = 0;
   bit          pend_we = 1'b0;
   logic [4:0]  pend_rd = '0;
   logic [31:0] pend_din = '0;
   bit          hold0 = 1'b0;
   bit          hold1 = 1'b0;
   logic [4:0]  cur0_rd, cur1_rd;
   logic [31:0] cur0_data, cur1_data;
   logic [31:0] ref_rf [NUM_REGS];
   logic [31:0] dut_rf [NUM_REGS];

   always @(posedge clk) begin
      if (bus.rf_reg_write === 1'b1) dut_rf[bus.rf_rd] <= bus.rf_rd_din;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected >=1");
         end else begin
            e = exp_q.pop_front();
            check("rf_reg_write", {31'd0, bus.rf_reg_write}, {31'd0, e.we});
            check("init_busy", {31'd0, bus.init_busy}, {31'd0, e.busy});
            check("req0_ready", {31'd0, bus.req0_ready}, {31'd0, e.rdy0});
            check("req1_ready", {31'd0, bus.req1_ready}, {31'd0, e.rdy1});
            if (e.chk_rd) begin
               check("rf_rd", {27'd0, bus.rf_rd}, {27'd0, e.rd});
               check("rf_rd_din", bus.rf_rd_din, e.din);
            end
         end
      end
   end

   task automatic new_req0();
      cur0_rd   = 5'($urandom_range(0, 31));
      cur0_data = $urandom;
   endtask

   task automatic new_req1();
      cur1_rd   = 5'($urandom_range(0, 31));
      cur1_data = $urandom;
   endtask

   task automatic step(input bit r, input bit v0, input bit v1);
      exp_t e;
      bit   run, f1, a0, a1;
      rst            = r;
      bus.req0_valid = v0;
      bus.req0_rd    = cur0_rd;
      bus.req0_data  = cur0_data;
      bus.req1_valid = v1;
      bus.req1_rd    = cur1_rd;
      bus.req1_data  = cur1_data;

      run    = (t > NUM_REGS);
      e.busy = (t <= NUM_REGS);
      if (t == 0) begin
         e.we = 1'b0; e.rd = '0; e.din = '0; e.chk_rd = 1'b1;
      end else if (t <= NUM_REGS) begin
         e.we = 1'b1; e.rd = 5'(t - 1); e.din = '0; e.chk_rd = 1'b1;
      end else begin
         e.we = pend_we; e.rd = pend_rd; e.din = pend_din; e.chk_rd = pend_we;
      end
      f1 = GUARD && (wcnt == MAX_WAIT) && v1;
      a0 = run && v0 && !f1;
      a1 = run && v1 && (!v0 || f1);
      e.rdy0 = a0;
      e.rdy1 = a1;
      exp_q.push_back(e);
      if (e.we) ref_rf[e.rd] = e.din;

      @(posedge clk);
      #1;
      if (r) begin
         t = 0; wcnt = 0; pend_we = 1'b0;
      end else begin
         if (t < 1000) t++;
         pend_we = 1'b0;
         if (a0) begin
            pend_we = (cur0_rd != 0); pend_rd = cur0_rd; pend_din = cur0_data;
         end else if (a1) begin
            pend_we = (cur1_rd != 0); pend_rd = cur1_rd; pend_din = cur1_data;
         end
         if (run) wcnt = (v1 && !a1) ? ((wcnt < MAX_WAIT) ? wcnt + 1 : wcnt) : 0;
      end
      hold0 = v0 && !a0 && !r;
      hold1 = v1 && !a1 && !r;
      if (!hold0) new_req0();
      if (!hold1) new_req1();
   endtask

   initial begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_rd = '0; bus.req0_data = '0;
      bus.req1_rd = '0; bus.req1_data = '0;
      cur0_rd = 5'd5;  cur0_data = 32'hDEADBEEF;
      cur1_rd = 5'd9;  cur1_data = 32'h0BAD_F00D;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      t = 0;
      mon_en = 1'b1;

      // Init sweep under pressure, then ch0 rd=5 beats a waiting ch1.
      while (t < NUM_REGS + 3) step(1'b0, 1'b1, 1'b1);
      check("readback_x5", dut_rf[5], 32'hDEADBEEF);

      // Lone ch1 request to x0: accepted, no write.
      cur1_rd = 5'd0; cur1_data = 32'h0000_1234;
      step(1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0, 1'b0);

      // Random traffic with occasional reset.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 63) == 0), hold0 | ($urandom_range(0, 1) == 1),
              hold1 | ($urandom_range(0, 1) == 1));
      end

      // Reset while the sweep is at rd=10.
      step(1'b1, 1'b1, 1'b1);
      while (t < 11) step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      while (t < NUM_REGS + 4) step(1'b0, hold0 | ($urandom_range(0, 1) == 1), 1'b1);

      // Reset in the same cycle as a ch0 rd=7 accept.
      while (hold0 || hold1) step(1'b0, hold0, hold1);
      cur0_rd = 5'd7; cur0_data = 32'h7777_0007;
      step(1'b1, 1'b1, 1'b0);
      while (t < NUM_REGS + 2) step(1'b0, 1'b0, 1'b0);

      // Both channels always valid: strict priority or 4:1 guarded pattern.
      for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b1);
      repeat (4) step(1'b0, 1'b0, 1'b0);

      mon_en = 1'b0;
      check("scoreboard_drained", exp_q.size(), 32'd0);
      for (int i = 0; i < NUM_REGS; i++) begin
         check($sformatf("rf_x%0d", i), dut_rf[i], ref_rf[i]);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
